alu_req_issuer: RTL

- Initiator side of the ALU valid/ready interface: buffers requests from upstream logic, drives one operation at a time into alu_design, and waits for its ready pulse.
- Returns the result, with a tag and an error code, on a downstream valid/ready channel.
- Screens DIV/REM-by-zero locally and guards against a hung ALU with a timeout.
- Sits between the datapath sequencer and alu_design.

---
 rtl/alu_req_issuer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_req_issuer.sv
// Initiator for alu_design: queues requests, runs one ALU operation at a time
// and returns each result in order with its tag and an error code.
module alu_req_issuer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             alu_valid_o,
    output logic [2:0]       alu_operation_o,
    output logic [31:0]      alu_operand_a_o,
    output logic [31:0]      alu_operand_b_o,
    input  logic             alu_ready_i,
    input  logic [31:0]      alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [1:0]       rsp_err_o,
    output logic             busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [2:0]       fifo_op  [DEPTH];
    logic [31:0]      fifo_a   [DEPTH];
    logic [31:0]      fifo_b   [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             ready_q, push, pop, fifo_empty, head_dbz, timed_out;

    logic [2:0]       hold_op;
    logic [31:0]      hold_a, hold_b, rsp_result_q;
    logic [TAG_W-1:0] hold_tag;
    logic [1:0]       rsp_err_q;
    logic [TMR_W-1:0] timer;

    assign fifo_empty = (count == '0);
    assign push       = req_valid_i && ready_q;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    assign head_dbz   = ((fifo_op[rd_ptr] == 3'b011) || (fifo_op[rd_ptr] == 3'b100))
                        && (fifo_b[rd_ptr] == 32'd0);
    assign timed_out  = (timer == TMR_W'(TIMEOUT - 1));

    // ready is registered from the post-update count, so a full FIFO refuses a push even while popping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_nxt;
            ready_q <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_op[wr_ptr]  <= req_op_i;
            fifo_a[wr_ptr]   <= req_a_i;
            fifo_b[wr_ptr]   <= req_b_i;
            fifo_tag[wr_ptr] <= req_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = head_dbz ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (alu_ready_i || timed_out) state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divide-by-zero is answered straight from the popped entry without touching the ALU
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_op      <= '0;
            hold_a       <= '0;
            hold_b       <= '0;
            hold_tag     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= '0;
            timer        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold_op  <= fifo_op[rd_ptr];
                        hold_a   <= fifo_a[rd_ptr];
                        hold_b   <= fifo_b[rd_ptr];
                        hold_tag <= fifo_tag[rd_ptr];
                        if (head_dbz) begin
                            rsp_result_q <= '0;
                            rsp_err_q    <= 2'b01;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (alu_ready_i) begin
                        rsp_result_q <= alu_result_i;
                        rsp_err_q    <= 2'b00;
                    end else if (timed_out) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 2'b10;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_valid_o = (state == ISSUE);
        rsp_valid_o = (state == RESP);
        busy_o      = (state != IDLE) || !fifo_empty;
    end

    assign req_ready_o     = ready_q;
    assign alu_operation_o = hold_op;
    assign alu_operand_a_o = hold_a;
    assign alu_operand_b_o = hold_b;
    assign rsp_result_o    = rsp_result_q;
    assign rsp_tag_o       = hold_tag;
    assign rsp_err_o       = rsp_err_q;
endmodule
